pq_client: RTL and testbench

- Initiator/controller that drives the priority-queue command interface (cmd/in/out/full/empty) on behalf of upstream producers and downstream consumers.
- Converts independent valid/ready push and pop streams into legal NOOP/PUSH/POP commands. Never pushes when full, never pops when empty.
- Captures the popped head value and returns it as a registered response.
- Drains the queue after reset or on flush, and tracks occupancy with a shadow counter used for protocol checking.

---
 rtl/pq_client.sv | 142 ++++++++++++++
 tb/tb_pq_client.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_client.sv
// Command-side controller for a min-priority queue: arbitrates push/pop
// requests into NOOP/PUSH/POP commands, returns popped heads and drains on flush.
module pq_client #(
    parameter int N   = 6,
    parameter int MSB = $clog2(N) - 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_valid,
    input  logic [MSB:0] push_data,
    output logic         push_ready,
    input  logic         pop_valid,
    output logic         pop_ready,
    output logic         resp_valid,
    output logic [MSB:0] resp_data,
    input  logic         flush,
    output logic         flush_done,
    output logic         proto_err,
    output logic [1:0]   cmd,
    output logic [MSB:0] in,
    input  logic [MSB:0] out,
    input  logic         full,
    input  logic         empty
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(N);

    localparam logic [1:0] CMD_NOOP = 2'd0;
    localparam logic [1:0] CMD_PUSH = 2'd1;
    localparam logic [1:0] CMD_POP  = 2'd2;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            arb_q, arb_d;
    logic            resp_valid_q, resp_valid_d;
    logic [MSB:0]    resp_data_q, resp_data_d;
    logic            flush_done_q, flush_done_d;
    logic            proto_err_q, proto_err_d;

    logic            push_ok;
    logic            pop_ok;
    logic            pick_pop;
    logic            occ_mismatch;

    // Handshake: a transfer happens on a cycle where valid && ready are both
    // high; ready never depends on anything but the current request, state,
    // queue status and arb, and a source must hold valid until it sees ready.
    always_comb begin
        push_ok      = push_valid && !full;
        pop_ok       = pop_valid && !empty;
        pick_pop     = pop_ok && (!push_ok || arb_q);
        occ_mismatch = ((count_q == '0) != empty) || ((count_q == COUNT_FULL) != full);
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        arb_d        = arb_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        flush_done_d = 1'b0;
        proto_err_d  = proto_err_q;
        cmd          = CMD_NOOP;
        in           = '0;
        push_ready   = 1'b0;
        pop_ready    = 1'b0;

        if (!reset) begin
            case (state_q)
                ST_FLUSH: begin
                    // The queue has no reset, so stale items are popped and dropped.
                    if (!empty) begin
                        cmd = CMD_POP;
                    end else begin
                        state_d      = ST_IDLE;
                        flush_done_d = 1'b1;
                        count_d      = '0;
                    end
                end
                ST_IDLE: begin
                    if (occ_mismatch) begin
                        proto_err_d = 1'b1;
                    end
                    if (flush) begin
                        state_d = ST_FLUSH;
                    end else begin
                        if (push_ok && pop_ok) begin
                            arb_d = ~arb_q;
                        end
                        if (pick_pop) begin
                            cmd          = CMD_POP;
                            pop_ready    = 1'b1;
                            resp_valid_d = 1'b1;
                            resp_data_d  = out;
                            count_d      = count_q - CW'(1);
                        end else if (push_ok) begin
                            cmd        = CMD_PUSH;
                            in         = push_data;
                            push_ready = 1'b1;
                            count_d    = count_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_FLUSH;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_FLUSH;
            count_q      <= '0;
            arb_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            flush_done_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            arb_q        <= arb_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            flush_done_q <= flush_done_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign flush_done = flush_done_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_pq_client.sv
// Bench for pq_client: a behavioural min-queue answers the commands, and a
// rule-level model of the client predicts commands, readys and responses.
module tb_pq_client;
  localparam int N   = 6;
  localparam int MSB = $clog2(N) - 1;
  localparam int W   = MSB + 1;

  logic         clock;
  logic         reset;
  logic         push_valid;
  logic [W-1:0] push_data;
  logic         push_ready;
  logic         pop_valid;
  logic         pop_ready;
  logic         resp_valid;
  logic [W-1:0] resp_data;
  logic         flush;
  logic         flush_done;
  logic         proto_err;
  logic [1:0]   cmd;
  logic [W-1:0] q_in;
  logic [W-1:0] q_out;
  logic         full;
  logic         empty;

  pq_client #(.N(N), .MSB(MSB)) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .flush(flush), .flush_done(flush_done), .proto_err(proto_err),
    .cmd(cmd), .in(q_in), .out(q_out), .full(full), .empty(empty)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int total = 0;
  int bad   = 0;

  // attached queue model (no reset, min at head)
  logic [W-1:0] pq[$];
  bit           force_empty = 1'b0;

  // client reference model
  bit           m_flushing = 1'b1;
  int           m_count = 0;
  bit           m_arb = 1'b0;
  bit           e_rv, e_fd, e_pe;
  logic [W-1:0] e_rd;

  // scoreboard and logs
  logic [W-1:0] exp_q[$];
  logic [W-1:0] resp_log[$];
  logic [1:0]   cmd_log[$];
  int n_push_cmd = 0, n_pop_cmd = 0, n_resp = 0, n_flush_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int pq_min_idx();
    int idx = 0;
    for (int i = 1; i < pq.size(); i++)
      if (pq[i] < pq[idx]) idx = i;
    return idx;
  endfunction

  task automatic drive_status();
    full  = (pq.size() == N);
    empty = force_empty || (pq.size() == 0);
    q_out = (pq.size() == 0) ? '0 : pq[pq_min_idx()];
  endtask

  // one clock: predict/compare Mealy outputs, let the edge happen, update models
  task automatic cycle();
    logic [1:0]   e_cmd;
    bit           e_pr, e_or, conflict, pok, ook;
    logic [W-1:0] e_in;
    logic [1:0]   c_seen;
    logic [W-1:0] in_seen, out_seen;
    bit           emp_s, full_s, rst_s, fl_s;
    #1;
    e_cmd = 2'd0; e_pr = 1'b0; e_or = 1'b0; e_in = '0; conflict = 1'b0;
    if (!reset) begin
      if (m_flushing) begin
        e_cmd = empty ? 2'd0 : 2'd2;
      end else if (!flush) begin
        pok = push_valid && !full;
        ook = pop_valid && !empty;
        conflict = pok && ook;
        if (ook && (!pok || m_arb)) begin
          e_cmd = 2'd2; e_or = 1'b1;
        end else if (pok) begin
          e_cmd = 2'd1; e_pr = 1'b1; e_in = push_data;
        end
      end
    end
    check_eq("cmd", 32'(cmd), 32'(e_cmd));
    check_eq("push_ready", 32'(push_ready), 32'(e_pr));
    check_eq("pop_ready", 32'(pop_ready), 32'(e_or));
    if (e_cmd == 2'd1) check_eq("in", 32'(q_in), 32'(e_in));
    c_seen = cmd; in_seen = q_in; out_seen = q_out;
    emp_s = empty; full_s = full; rst_s = reset; fl_s = flush;

    @(posedge clock);
    #1;
    if (c_seen == 2'd1 && pq.size() < N) pq.push_back(in_seen);
    else if (c_seen == 2'd2 && pq.size() > 0) pq.delete(pq_min_idx());
    if (c_seen == 2'd1) n_push_cmd++;
    if (c_seen == 2'd2) n_pop_cmd++;
    cmd_log.push_back(c_seen);

    if (rst_s) begin
      m_flushing = 1'b1; m_count = 0; m_arb = 1'b0;
      e_rv = 1'b0; e_rd = '0; e_fd = 1'b0; e_pe = 1'b0;
      exp_q.delete();
    end else begin
      e_rv = 1'b0; e_fd = 1'b0;
      if (m_flushing) begin
        if (emp_s) begin
          m_flushing = 1'b0; e_fd = 1'b1; m_count = 0;
        end
      end else begin
        if (((m_count == 0) != emp_s) || ((m_count == N) != full_s)) e_pe = 1'b1;
        if (fl_s) begin
          m_flushing = 1'b1;
        end else begin
          if (conflict) m_arb = !m_arb;
          if (e_cmd == 2'd1) m_count++;
          if (e_cmd == 2'd2) begin
            m_count--; e_rv = 1'b1; e_rd = out_seen;
            exp_q.push_back(out_seen);
          end
        end
      end
    end
    check_eq("resp_valid", 32'(resp_valid), 32'(e_rv));
    check_eq("resp_data", 32'(resp_data), 32'(e_rd));
    check_eq("flush_done", 32'(flush_done), 32'(e_fd));
    check_eq("proto_err", 32'(proto_err), 32'(e_pe));
    if (resp_valid === 1'b1) begin
      n_resp++;
      resp_log.push_back(resp_data);
      check_eq("resp_sb_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_eq("resp_sb", 32'(resp_data), 32'(exp_q.pop_front()));
    end
    if (flush_done === 1'b1) n_flush_done++;
    drive_status();
    @(negedge clock);
  endtask

  task automatic run_until_flush_done(input int budget, output int ncyc);
    int base_fd = n_flush_done;
    ncyc = 0;
    while (n_flush_done == base_fd && ncyc < budget) begin
      cycle();
      ncyc++;
    end
    check_eq("flush_done_seen", 32'(n_flush_done - base_fd), 32'd1);
  endtask

  initial begin
    logic [W-1:0] plist[6];
    int base_pop, base_resp, base_push, ncyc, idx;

    reset = 1'b1; push_valid = 1'b0; push_data = '0; pop_valid = 1'b0; flush = 1'b0;
    pq = '{3'd4, 3'd2, 3'd6};
    drive_status();

    // reset with 3 stale items: 3 drain POPs, NOOP, then flush_done
    cycle();
    cycle();
    reset = 1'b0;
    base_pop = n_pop_cmd; base_resp = n_resp;
    run_until_flush_done(10, ncyc);
    check_eq("rst_drain_cycles", 32'(ncyc), 32'd4);
    check_eq("rst_drain_pops", 32'(n_pop_cmd - base_pop), 32'd3);
    check_eq("rst_no_resp", 32'(n_resp - base_resp), 32'd0);
    check_eq("rst_queue_empty", 32'(pq.size()), 32'd0);
    check_eq("rst_proto", 32'(proto_err), 32'd0);

    // fill to full back-to-back, then a held 7th push
    plist = '{3'd3, 3'd1, 3'd2, 3'd1, 3'd2, 3'd0};
    idx = 0; ncyc = 0;
    push_valid = 1'b1;
    while (idx < 6 && ncyc < 12) begin
      push_data = plist[idx];
      base_push = n_push_cmd;
      cycle();
      ncyc++;
      if (n_push_cmd != base_push) idx++;
    end
    check_eq("fill_cycles", 32'(ncyc), 32'd6);
    check_eq("fill_full", 32'(full), 32'd1);
    push_data = 3'd4;
    base_push = n_push_cmd;
    repeat (3) cycle();
    check_eq("full_held_push", 32'(n_push_cmd - base_push), 32'd0);
    push_valid = 1'b0;

    // three pops return the smallest items in order
    resp_log.delete();
    pop_valid = 1'b1;
    repeat (3) cycle();
    pop_valid = 1'b0;
    check_eq("pop3_count", 32'(resp_log.size()), 32'd3);
    if (resp_log.size() == 3) begin
      check_eq("pop3_0", 32'(resp_log[0]), 32'd0);
      check_eq("pop3_1", 32'(resp_log[1]), 32'd1);
      check_eq("pop3_2", 32'(resp_log[2]), 32'd1);
    end

    // conflict arbitration alternates starting with PUSH
    cmd_log.delete();
    push_valid = 1'b1; pop_valid = 1'b1; push_data = 3'd4;
    repeat (4) cycle();
    push_valid = 1'b0; pop_valid = 1'b0;
    if (cmd_log.size() == 4) begin
      check_eq("arb_0", 32'(cmd_log[0]), 32'd1);
      check_eq("arb_1", 32'(cmd_log[1]), 32'd2);
      check_eq("arb_2", 32'(cmd_log[2]), 32'd1);
      check_eq("arb_3", 32'(cmd_log[3]), 32'd2);
    end
    check_eq("arb_net_size", 32'(pq.size()), 32'd3);

    // drain with pops, pop on empty, then push 5 and pop it back
    pop_valid = 1'b1;
    ncyc = 0;
    while (pq.size() != 0 && ncyc < 10) begin
      cycle();
      ncyc++;
    end
    check_eq("drain_empty", 32'(pq.size()), 32'd0);
    base_pop = n_pop_cmd; base_resp = n_resp;
    repeat (3) cycle();
    check_eq("empty_no_pop", 32'(n_pop_cmd - base_pop), 32'd0);
    check_eq("empty_no_resp", 32'(n_resp - base_resp), 32'd0);
    push_valid = 1'b1; push_data = 3'd5;
    cycle();
    push_valid = 1'b0;
    cycle();
    pop_valid = 1'b0;
    cycle();
    check_eq("push5_resp", 32'(resp_log[$]), 32'd5);

    // occupancy mismatch is sticky; flush with 4 items
    push_valid = 1'b1;
    push_data = 3'd7; cycle();
    push_data = 3'd6; cycle();
    push_valid = 1'b0;
    force_empty = 1'b1; drive_status();
    cycle();
    force_empty = 1'b0; drive_status();
    check_eq("proto_set", 32'(proto_err), 32'd1);
    repeat (3) cycle();
    check_eq("proto_sticky", 32'(proto_err), 32'd1);
    push_valid = 1'b1;
    push_data = 3'd3; cycle();
    push_data = 3'd5; cycle();
    push_valid = 1'b0;
    base_pop = n_pop_cmd; base_resp = n_resp;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    run_until_flush_done(12, ncyc);
    check_eq("flush_pops", 32'(n_pop_cmd - base_pop), 32'd4);
    check_eq("flush_no_resp", 32'(n_resp - base_resp), 32'd0);
    check_eq("flush_proto_kept", 32'(proto_err), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("proto_cleared", 32'(proto_err), 32'd0);
    run_until_flush_done(4, ncyc);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      push_valid = 1'($urandom_range(0, 1));
      pop_valid  = 1'($urandom_range(0, 1));
      push_data  = W'($urandom_range(0, (1 << W) - 1));
      flush      = ($urandom_range(0, 29) == 0);
      reset      = ($urandom_range(0, 149) == 0);
      cycle();
    end
    push_valid = 1'b0; pop_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    repeat (12) cycle();
    check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("final_proto", 32'(proto_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
